// File: rtl/packet_dispatcher_if.sv
// Bundle of the requester-side and router-side signals of packet_dispatcher.
// The master modport is the dispatcher's view; the slave modport is the environment's view.
interface packet_dispatcher_if #(
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int NUM_REQ         = 4
);
  localparam int NODE_W = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
  localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ID_W   = PACKET_ID_WIDTH;
  localparam int FLIT_W = 1 + 2*NODE_W + ID_W + 17 + 2;

  // Requester handshake: a packet moves when req_valid[r] & req_ready[r] are both high.
  // req_ready is one-hot at most and never depends on anything but req_valid, ce and state.
  // Router handshake: a flit moves when flit_valid & flit_ready & ce; flit_out is stable until then.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*68-1:0]     req_packet;
  logic [NUM_REQ*NODE_W-1:0] req_dest;
  logic [FLIT_W-1:0]         flit_out;
  logic                      flit_valid;
  logic                      flit_ready;
  logic [REQ_W-1:0]          grant_idx;
  logic                      busy;
  logic                      dbg_state;

  modport master (
    input  req_valid, req_packet, req_dest, flit_ready,
    output req_ready, flit_out, flit_valid, grant_idx, busy, dbg_state
  );

  modport slave (
    output req_valid, req_packet, req_dest, flit_ready,
    input  req_ready, flit_out, flit_valid, grant_idx, busy, dbg_state
  );
endinterface

// File: rtl/packet_dispatcher.sv
// Round-robin injection scheduler: accepts one 68-bit packet from NUM_REQ requesters and
// serialises it into 4 flits of 17 data bits, tagging each packet with a rolling packet ID.
module packet_dispatcher #(
  parameter int NODE_COUNT      = 8,
  parameter int NODE_ID         = 0,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int NUM_REQ         = 4
) (
  input logic                clk,
  input logic                rst,
  input logic                ce,
  packet_dispatcher_if.master bus
);
  localparam int NODE_W = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1;
  localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ID_W   = PACKET_ID_WIDTH;
  localparam int FLIT_W = 1 + 2*NODE_W + ID_W + 17 + 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [REQ_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
  logic [ID_W-1:0]   pid_q, pid_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [67:0]       pkt_q, pkt_d;
  logic [NODE_W-1:0] dest_q, dest_d;

  logic              found_hi, found_lo, sel_found;
  logic [REQ_W-1:0]  idx_hi, idx_lo, sel_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [67:0]       sel_pkt;
  logic [NODE_W-1:0] sel_dest;
  logic              accept, xfer;
  logic [16:0]       flit_data;

  // Round-robin search: first valid at or above rr_ptr, otherwise the lowest valid (wrap).
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_hi && bus.req_valid[j] && (REQ_W'(j) >= rr_ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = REQ_W'(j);
      end
      if (!found_lo && bus.req_valid[j]) begin
        found_lo = 1'b1;
        idx_lo   = REQ_W'(j);
      end
    end
    sel_found = found_hi | found_lo;
    sel_idx   = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    grant_oh = '0;
    if (state_q == S_IDLE && ce && sel_found) begin
      grant_oh[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_pkt  = '0;
    sel_dest = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == REQ_W'(i)) begin
        sel_pkt  = bus.req_packet[i*68 +: 68];
        sel_dest = bus.req_dest[i*NODE_W +: NODE_W];
      end
    end
  end

  assign accept = |(grant_oh & bus.req_valid);
  assign xfer   = (state_q == S_SEND) && ce && bus.flit_ready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    id_cnt_d   = id_cnt_q;
    pid_d      = pid_q;
    byte_idx_d = byte_idx_q;
    pkt_d      = pkt_q;
    dest_d     = dest_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          pkt_d      = sel_pkt;
          dest_d     = sel_dest;
          pid_d      = id_cnt_q;
          grant_d    = sel_idx;
          byte_idx_d = 2'd0;
          id_cnt_d   = id_cnt_q + 1'b1;
          rr_ptr_d   = (sel_idx == REQ_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      id_cnt_q   <= '0;
      pid_q      <= '0;
      byte_idx_q <= 2'd0;
      pkt_q      <= '0;
      dest_q     <= '0;
    end else if (ce) begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      id_cnt_q   <= id_cnt_d;
      pid_q      <= pid_d;
      byte_idx_q <= byte_idx_d;
      pkt_q      <= pkt_d;
      dest_q     <= dest_d;
    end
  end

  // Byte 0 is the most significant slice so the collector can concatenate in arrival order.
  always_comb begin
    flit_data = '0;
    unique case (byte_idx_q)
      2'd0: flit_data = pkt_q[67:51];
      2'd1: flit_data = pkt_q[50:34];
      2'd2: flit_data = pkt_q[33:17];
      2'd3: flit_data = pkt_q[16:0];
      default: flit_data = '0;
    endcase
  end

  assign bus.flit_out   = (state_q == S_SEND)
                        ? {1'b1, dest_q, flit_data, pid_q, NODE_W'(NODE_ID), byte_idx_q}
                        : FLIT_W'(0);
  assign bus.flit_valid = (state_q == S_SEND);
  assign bus.busy       = (state_q == S_SEND);
  assign bus.req_ready  = grant_oh;
  assign bus.grant_idx  = grant_q;
  assign bus.dbg_state  = state_q;
endmodule
